// File: rtl/dl_skid_buf.sv
// dl_skid_buf: two-entry valid/ready skid buffer.
//
// Breaks the combinational ready path between upstream and downstream while
// sustaining one beat per cycle. All outputs come straight from flops.
//
// Ports:
//   clk        sole clock, all state updates on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   upstream beat present on in_data
//   in_ready   buffer can take a beat this cycle (registered)
//   in_data    upstream payload
//   out_valid  out_data holds a beat (registered)
//   out_ready  downstream takes the beat this cycle
//   out_data   downstream payload, driven by the main register
module dl_skid_buf #(
  parameter int unsigned NUM_BITS = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_BITS-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_BITS-1:0] out_data
);

  typedef enum logic [1:0] {
    StEmpty = 2'd0,  // no entries held
    StFull  = 2'd1,  // main register only
    StSkid  = 2'd2   // main and skid registers
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_BITS-1:0] main_q, main_d;
  logic [NUM_BITS-1:0] skid_q, skid_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                in_fire, out_fire;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      StEmpty: begin
        if (in_fire) begin
          state_d = StFull;
          main_d  = in_data;
        end
      end
      StFull: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          // Downstream stalled: park the new beat behind the current one.
          state_d = StSkid;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = StEmpty;
        end
      end
      StSkid: begin
        if (out_fire) begin
          state_d = StFull;
          main_d  = skid_q;
        end
      end
      default: state_d = StEmpty;
    endcase
    // Flags are precomputed from the next state so they leave the block as flops.
    in_ready_d  = (state_d != StSkid);
    out_valid_d = (state_d != StEmpty);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      main_q      <= '0;
      skid_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      main_q      <= main_d;
      skid_q      <= skid_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = main_q;

endmodule

// File: tb/tb_dl_skid_buf.sv
// Testbench for dl_skid_buf (NUM_BITS = 8).
// Reference model: an ideal FIFO of capacity two. It accepts while it holds
// fewer than two beats, presents its head whenever non-empty, and is emptied
// by reset. Accepted beats are pushed at the clock edge; a monitor on the
// falling edge compares the DUT against the model and pops on out_fire.
module tb_dl_skid_buf;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q[$];
  bit           acc_ok   = 1'b1;
  bit           checking = 1'b0;

  dl_skid_buf #(
    .NUM_BITS(W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data)
  );

  always #5 clk = ~clk;

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic check_byte(input string name, input logic [W-1:0] act,
                            input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Model update at the edge: reset empties the FIFO, otherwise accept on in_fire.
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      acc_ok   = 1'b1;
      checking = 1'b1;
    end else if (in_valid && acc_ok) begin
      exp_q.push_back(in_data);
    end
  end

  // Monitor: compare flags and head of FIFO, pop when the beat is taken.
  always @(negedge clk) begin
    if (checking) begin
      bit exp_rdy;
      bit exp_vld;
      exp_rdy = (exp_q.size() < 2);
      exp_vld = (exp_q.size() > 0);
      check_bit("in_ready", in_ready, exp_rdy);
      check_bit("out_valid", out_valid, exp_vld);
      if (exp_vld) begin
        check_byte("out_data", out_data, exp_q[0]);
        if (out_ready && rst_n) void'(exp_q.pop_front());
      end
      acc_ok = exp_rdy;
    end
  end

  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;

    // Reset with a beat offered: it must not be captured.
    step(1'b1, 8'hAA, 1'b1);
    rst_n = 1'b1;
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_bit("rst_in_ready", in_ready, 1'b1);
    check_byte("rst_out_data", out_data, 8'h00);
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // Streaming with downstream always ready.
    for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b1);
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // Backpressure: fill main and skid, third beat held upstream.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    repeat (3) step(1'b1, 8'h33, 1'b0);
    check_byte("bp_out_data", out_data, 8'h11);
    check_bit("bp_in_ready", in_ready, 1'b0);
    // Drain from SKID: 0x33 is taken once in_ready returns.
    step(1'b1, 8'h33, 1'b1);
    check_bit("drain_in_ready", in_ready, 1'b1);
    step(1'b1, 8'h33, 1'b1);
    repeat (4) step(1'b0, 8'h00, 1'b1);

    // Reset while in SKID discards both entries.
    step(1'b1, 8'h44, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    rst_n = 1'b0;
    step(1'b0, 8'h00, 1'b0);
    rst_n = 1'b1;
    check_bit("skidrst_out_valid", out_valid, 1'b0);
    check_byte("skidrst_out_data", out_data, 8'h00);
    step(1'b1, 8'h66, 1'b0);
    check_byte("post_rst_first", out_data, 8'h66);
    repeat (3) step(1'b0, 8'h00, 1'b1);

    // Random traffic with rare resets.
    for (int i = 0; i < 10000; i++) begin
      rst_n = ($urandom_range(0, 499) != 0);
      step(1'(($urandom_range(0, 3)) != 0), W'($urandom), 1'($urandom_range(0, 1)));
    end
    rst_n = 1'b1;
    repeat (4) step(1'b0, 8'h00, 1'b1);
    check_bit("final_out_valid", out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
